// File: rtl/pwu_pkg.sv
// Shared types and helpers for the PWU walker response path.
package pwu_pkg;

   localparam int PA_W = 28;

   typedef struct packed {
      logic            fault;
      logic [PA_W-1:0] pa;
   } pa_entry_t;

   // Increments val unless it has already reached max; callers pass the all-ones value of their width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
      return (val >= max) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO: the head entry is always visible on rd_data_o while not empty.
module sync_fifo_fwft #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 29,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en_i) wptr_d = wptr_q + PTR_W'(1);
         if (rd_en_i) rptr_d = rptr_q + PTR_W'(1);
         if (wr_en_i && !rd_en_i)      count_d = count_q + CNT_W'(1);
         else if (rd_en_i && !wr_en_i) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; its contents only matter once count_q says so.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !clr_i) mem_q[wptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rptr_q];
   assign count_o   = count_q;
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/pa_resp_buffer.sv
// Buffers walker translations for the PA consumer, back-pressures the walker via stall_o,
// and keeps a saturating fault counter plus a sticky overflow flag.
module pa_resp_buffer
   import pwu_pkg::*;
#(
   parameter  int DEPTH        = 4,
   parameter  int STALL_MARGIN = 1,
   parameter  int FCNT_W       = 16,
   localparam int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [PA_W-1:0]   pa_i,
   input  logic              pa_fault_i,
   input  logic              pa_vld_i,
   output logic              pa_rdy_o,
   output logic              stall_o,
   input  logic              flush_i,
   output logic [PA_W-1:0]   out_pa_o,
   output logic              out_fault_o,
   output logic              out_vld_o,
   input  logic              out_rdy_i,
   output logic [FCNT_W-1:0] fault_cnt_o,
   output logic              overflow_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam logic [31:0] FCNT_MAX = 32'((64'd1 << FCNT_W) - 64'd1);

   pa_entry_t         wr_entry, rd_entry;
   logic [CNT_W-1:0]  count;
   logic              full, empty, wr, rd;
   logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
   logic              overflow_q, overflow_d;

   assign wr_entry = '{fault: pa_fault_i, pa: pa_i};
   assign wr       = pa_vld_i && !full && !flush_i;
   assign rd       = !empty && out_rdy_i && !flush_i;

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(pa_entry_t))
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (flush_i),
      .wr_en_i   (wr),
      .wr_data_i (wr_entry),
      .rd_en_i   (rd),
      .rd_data_o (rd_entry),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty)
   );

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      overflow_d  = overflow_q;
      if (wr && pa_fault_i) fault_cnt_d = FCNT_W'(sat_inc(32'(fault_cnt_q), FCNT_MAX));
      if (pa_vld_i && full && !flush_i) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fault_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         fault_cnt_q <= fault_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pa_rdy_o    = !full;
   // Free entries <= margin, rewritten as a compare on occupancy.
   assign stall_o     = (count >= CNT_W'(DEPTH - STALL_MARGIN));
   assign out_vld_o   = !empty;
   assign out_pa_o    = rd_entry.pa;
   assign out_fault_o = rd_entry.fault;
   assign fault_cnt_o = fault_cnt_q;
   assign overflow_o  = overflow_q;
   assign count_o     = count;

endmodule
